// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - game rectangle type, target indices and wall rectangles
//
// Purpose: rectangle struct used by the collision path, the fixed order in
// which targets are checked, and the constant wall rectangles.
// Ports: none (package).
package pong_pkg;

  import vga_pkg::*;

  // Target index order; bit k of the hit vector belongs to target k.
  localparam int TGT_PADL = 0;
  localparam int TGT_PADR = 1;
  localparam int TGT_TOP  = 2;
  localparam int TGT_BOT  = 3;

  typedef struct packed {
    logic [X_POS_W-1:0] left;
    logic [X_POS_W-1:0] right;
    logic [Y_POS_W-1:0] top;
    logic [Y_POS_W-1:0] bottom;
  } rect_t;

  localparam rect_t TOP_WALL_RECT = '{
    left:   '0,
    right:  X_POS_W'(H_ACTIVE),
    top:    '0,
    bottom: Y_POS_W'(WALL_H)
  };

  localparam rect_t BOT_WALL_RECT = '{
    left:   '0,
    right:  X_POS_W'(H_ACTIVE),
    top:    Y_POS_W'(V_ACTIVE - WALL_H),
    bottom: Y_POS_W'(V_ACTIVE)
  };

endpackage

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA coordinate widths and active-area geometry
//
// Purpose: screen geometry shared by the timing, game-state and collision
// logic. Positions are pixel coordinates inside the active area.
// Ports: none (package).
package vga_pkg;

  localparam int X_POS_W  = 10;
  localparam int Y_POS_W  = 10;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Thickness of the top and bottom walls in pixels.
  localparam int WALL_H   = 8;

endpackage

// File: rtl/collision_scheduler_if.sv
// rtl/collision_scheduler_if.sv - rectangle inputs and hit/status outputs of the collision scheduler
//
// Purpose: bundles the frame strobe, the ball and paddle rectangles and the
// scheduler results.
// Signals:
//   frame_start_i              single-cycle strobe, start a frame check
//   ball_*_i / padl_*_i / padr_*_i  rectangle bounds (x: X_POS_W, y: Y_POS_W)
//   hit_o      [N_TGT]         per-target hit vector of the last completed check
//   done_o                     one-cycle strobe, hit_o just updated
//   busy_o                     check in progress
//   overrun_o                  one-cycle strobe, frame_start_i dropped while busy
// Modports: master drives the rectangles and strobe, slave is the scheduler.
interface collision_scheduler_if #(
  parameter int N_TGT = 4
) ();

  logic                        frame_start_i;
  logic [vga_pkg::X_POS_W-1:0] ball_left_i;
  logic [vga_pkg::X_POS_W-1:0] ball_right_i;
  logic [vga_pkg::Y_POS_W-1:0] ball_top_i;
  logic [vga_pkg::Y_POS_W-1:0] ball_bottom_i;
  logic [vga_pkg::X_POS_W-1:0] padl_left_i;
  logic [vga_pkg::X_POS_W-1:0] padl_right_i;
  logic [vga_pkg::Y_POS_W-1:0] padl_top_i;
  logic [vga_pkg::Y_POS_W-1:0] padl_bottom_i;
  logic [vga_pkg::X_POS_W-1:0] padr_left_i;
  logic [vga_pkg::X_POS_W-1:0] padr_right_i;
  logic [vga_pkg::Y_POS_W-1:0] padr_top_i;
  logic [vga_pkg::Y_POS_W-1:0] padr_bottom_i;
  logic [N_TGT-1:0]            hit_o;
  logic                        done_o;
  logic                        busy_o;
  logic                        overrun_o;

  modport master (
    output frame_start_i,
    output ball_left_i, ball_right_i, ball_top_i, ball_bottom_i,
    output padl_left_i, padl_right_i, padl_top_i, padl_bottom_i,
    output padr_left_i, padr_right_i, padr_top_i, padr_bottom_i,
    input  hit_o, done_o, busy_o, overrun_o
  );

  modport slave (
    input  frame_start_i,
    input  ball_left_i, ball_right_i, ball_top_i, ball_bottom_i,
    input  padl_left_i, padl_right_i, padl_top_i, padl_bottom_i,
    input  padr_left_i, padr_right_i, padr_top_i, padr_bottom_i,
    output hit_o, done_o, busy_o, overrun_o
  );

endinterface

// File: rtl/sprite_collision.sv
// rtl/sprite_collision.sv - two-stage pipelined strict rectangle overlap checker
//
// Purpose: reports whether rect1 and rect2 overlap. Edges that merely touch
// do not count. Result appears two cycles after the inputs are driven.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   rect1_i      first rectangle
//   rect2_i      second rectangle
//   collision_o  registered overlap result
module sprite_collision
  import pong_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  rect_t rect1_i,
  input  rect_t rect2_i,
  output logic  collision_o
);

  // Stage 1 holds the four edge comparisons, stage 2 combines them.
  logic [3:0] cmp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmp_q       <= '0;
      collision_o <= 1'b0;
    end else begin
      cmp_q <= {rect1_i.left   < rect2_i.right,
                rect1_i.right  > rect2_i.left,
                rect1_i.top    < rect2_i.bottom,
                rect1_i.bottom > rect2_i.top};
      collision_o <= &cmp_q;
    end
  end

endmodule

// File: rtl/collision_scheduler.sv
// rtl/collision_scheduler.sv - time-shares one overlap checker across paddles and walls per frame
//
// Purpose: on frame_start snapshots the ball and paddle rectangles, issues
// one target per cycle into the shared sprite_collision pipeline, collects
// results through a tag pipeline and publishes the hit vector with done.
// Ports:
//   clk_i   system clock
//   rst_ni  synchronous active-low reset
//   bus     collision_scheduler_if.slave (strobe, rectangles, hit/done/busy/overrun)
module collision_scheduler
  import pong_pkg::*;
#(
  parameter int N_TGT   = 4,
  parameter int CHK_LAT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  collision_scheduler_if.slave bus
);

  localparam int IDX_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TGT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  logic [1:0]       state_q;
  logic [IDX_W-1:0] idx_q;
  rect_t            ball_q, padl_q, padr_q;
  rect_t            ball_in, padl_in, padr_in;
  rect_t            tgt_rect;
  tag_t             tag_q [CHK_LAT];
  tag_t             tag_in, tag_out;
  logic [N_TGT-1:0] shadow_q, shadow_nxt, hit_bit, hit_q;
  logic             collision;
  logic             last_capture;

  assign ball_in = '{left: bus.ball_left_i, right: bus.ball_right_i,
                     top: bus.ball_top_i, bottom: bus.ball_bottom_i};
  assign padl_in = '{left: bus.padl_left_i, right: bus.padl_right_i,
                     top: bus.padl_top_i, bottom: bus.padl_bottom_i};
  assign padr_in = '{left: bus.padr_left_i, right: bus.padr_right_i,
                     top: bus.padr_top_i, bottom: bus.padr_bottom_i};

  // Target rectangle for the current issue slot, always from the snapshot.
  always_comb begin
    tgt_rect = BOT_WALL_RECT;
    case (idx_q)
      IDX_W'(TGT_PADL): tgt_rect = padl_q;
      IDX_W'(TGT_PADR): tgt_rect = padr_q;
      IDX_W'(TGT_TOP):  tgt_rect = TOP_WALL_RECT;
      default:          tgt_rect = BOT_WALL_RECT;
    endcase
  end

  sprite_collision u_chk (
    .clk_i       (clk_i),
    .rst_i       (~rst_ni),
    .rect1_i     (ball_q),
    .rect2_i     (tgt_rect),
    .collision_o (collision)
  );

  // The tag travels alongside the checker so each result knows its target.
  assign tag_in  = '{valid: (state_q == ST_ISSUE), idx: idx_q};
  assign tag_out = tag_q[CHK_LAT-1];

  assign hit_bit      = (tag_out.valid && collision) ? (N_TGT'(1) << tag_out.idx) : '0;
  assign shadow_nxt   = shadow_q | hit_bit;
  assign last_capture = tag_out.valid && (tag_out.idx == LAST_IDX);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      ball_q   <= '0;
      padl_q   <= '0;
      padr_q   <= '0;
      shadow_q <= '0;
      hit_q    <= '0;
      for (int i = 0; i < CHK_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < CHK_LAT; i++) tag_q[i] <= tag_q[i-1];
      shadow_q <= shadow_nxt;

      case (state_q)
        ST_IDLE: begin
          if (bus.frame_start_i) begin
            ball_q   <= ball_in;
            padl_q   <= padl_in;
            padr_q   <= padr_in;
            shadow_q <= '0;
            idx_q    <= '0;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Publish including the result captured on this same edge.
          if (last_capture) begin
            hit_q   <= shadow_nxt;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.hit_o     = hit_q;
  assign bus.done_o    = (state_q == ST_DONE);
  assign bus.busy_o    = (state_q != ST_IDLE);
  assign bus.overrun_o = bus.frame_start_i && (state_q != ST_IDLE);

endmodule

// File: tb/tb_collision_scheduler.sv
// tb/tb_collision_scheduler.sv - directed self-checking bench for collision_scheduler
module tb_collision_scheduler;

  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  collision_scheduler_if #(.N_TGT(4)) bus ();

  collision_scheduler #(.N_TGT(4), .CHK_LAT(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ball(int l, int r, int t, int b);
    bus.ball_left_i   = X_POS_W'(l);
    bus.ball_right_i  = X_POS_W'(r);
    bus.ball_top_i    = Y_POS_W'(t);
    bus.ball_bottom_i = Y_POS_W'(b);
  endtask

  task automatic set_padl(int l, int r, int t, int b);
    bus.padl_left_i   = X_POS_W'(l);
    bus.padl_right_i  = X_POS_W'(r);
    bus.padl_top_i    = Y_POS_W'(t);
    bus.padl_bottom_i = Y_POS_W'(b);
  endtask

  task automatic set_padr(int l, int r, int t, int b);
    bus.padr_left_i   = X_POS_W'(l);
    bus.padr_right_i  = X_POS_W'(r);
    bus.padr_top_i    = Y_POS_W'(t);
    bus.padr_bottom_i = Y_POS_W'(b);
  endtask

  // Runs one frame check starting now (cycle 0) and ends in cycle 8.
  // move_at: cycle in which the ball input is moved away (ignored result).
  // restart_at: cycle in which a second frame_start is pulsed.
  task automatic frame(string name, logic [3:0] exp_hit, logic [3:0] prev_hit,
                       int move_at, int restart_at);
    bus.frame_start_i = 1'b1;
    #1;
    chk({name, " c0 busy"}, bus.busy_o, 0);
    chk({name, " c0 done"}, bus.done_o, 0);
    chk({name, " c0 overrun"}, bus.overrun_o, 0);
    tick();
    for (int c = 1; c <= 7; c++) begin
      bus.frame_start_i = (c == restart_at);
      if (c == move_at) set_ball(300, 308, 300, 308);
      #1;
      chk($sformatf("%s c%0d busy", name, c), bus.busy_o, 1);
      chk($sformatf("%s c%0d done", name, c), bus.done_o, (c == 7) ? 1 : 0);
      chk($sformatf("%s c%0d overrun", name, c), bus.overrun_o, (c == restart_at) ? 1 : 0);
      chk($sformatf("%s c%0d hit", name, c), bus.hit_o, (c == 7) ? exp_hit : prev_hit);
      tick();
    end
    bus.frame_start_i = 1'b0;
    #1;
    chk({name, " c8 busy"}, bus.busy_o, 0);
    chk({name, " c8 done"}, bus.done_o, 0);
    chk({name, " c8 hit"}, bus.hit_o, exp_hit);
  endtask

  initial begin
    bus.frame_start_i = 1'b0;
    set_ball(100, 108, 200, 208);
    set_padl(10, 18, 180, 240);
    set_padr(620, 628, 180, 240);

    tick(); tick(); tick();
    chk("reset hit", bus.hit_o, 0);
    chk("reset done", bus.done_o, 0);
    chk("reset busy", bus.busy_o, 0);
    chk("reset overrun", bus.overrun_o, 0);
    rst_n = 1'b1;
    tick();

    frame("no_hit", 4'b0000, 4'b0000, -1, -1);

    set_ball(15, 23, 200, 208);
    frame("padl_hit", 4'b0001, 4'b0000, -1, -1);

    set_ball(18, 26, 200, 208);
    frame("padl_touch", 4'b0000, 4'b0001, -1, -1);

    set_ball(100, 108, 5, 13);
    frame("top_wall", 4'b0100, 4'b0000, -1, -1);

    set_ball(100, 108, V_ACTIVE - 10, V_ACTIVE - 2);
    frame("bot_wall", 4'b1000, 4'b0100, -1, -1);

    set_ball(622, 630, V_ACTIVE - 10, V_ACTIVE - 2);
    set_padr(620, 628, 440, 479);
    frame("padr_bot", 4'b1010, 4'b1000, -1, -1);
    set_padr(620, 628, 180, 240);

    // Second strobe in cycle 3 and ball moved in cycle 2: snapshot wins.
    set_ball(15, 23, 200, 208);
    frame("overrun", 4'b0001, 4'b1010, 2, 3);

    // Reset asserted in cycle 4 of a check.
    set_ball(100, 108, 200, 208);
    bus.frame_start_i = 1'b1;
    #1;
    tick();
    bus.frame_start_i = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("abort c4 busy", bus.busy_o, 1);
    tick();
    chk("abort c5 hit", bus.hit_o, 0);
    chk("abort c5 busy", bus.busy_o, 0);
    chk("abort c5 done", bus.done_o, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 6; c < 10; c++) begin
      #1;
      chk($sformatf("abort c%0d done", c), bus.done_o, 0);
      chk($sformatf("abort c%0d busy", c), bus.busy_o, 0);
      tick();
    end

    set_ball(15, 23, 200, 208);
    frame("restart", 4'b0001, 4'b0000, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
